// File: rtl/funnel_shift_seq.sv
// Sequential funnel/barrel shifter with a valid/ready request and result handshake.
// The result is built over SW+1 cycles: one conditional power-of-two right
// shift of a 2W-bit working word per cycle. Left shifts and left rotates are
// handled by bit-reversing the operand on the way in and the result on the way out.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | one shift stage per cycle, stage counter 0..SW
// DONE  | result presented with out_valid high until out_ready
module funnel_shift_seq #(
  parameter int W  = 16,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    f,
  input  logic [SW:0]   s,
  input  logic [W-1:0]  i,
  input  logic [W-1:0]  h,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  o,
  output logic          co,
  output logic          z
);

  localparam int SWP = SW + 1;
  localparam int CW  = $clog2(SW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    stg_q, stg_d;
  logic [2*W-1:0]   word_q, word_d;
  logic [SW:0]      amt_q, amt_d;
  logic             rev_q, rev_d;
  logic             cop_q, cop_d;
  logic [W-1:0]     o_q, o_d;
  logic             co_q, co_d;
  logic             z_q, z_d;

  logic [SW:0]      seff;
  logic [SW-1:0]    idx_r;
  logic [SW-1:0]    idx_l;
  logic [W-1:0]     i_rev;
  logic [SW:0]      sh_amt;
  logic [2*W-1:0]   stage_word;
  logic [W-1:0]     res;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = v[W-1-k];
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o         = o_q;
  assign co        = co_q;
  assign z         = z_q;

  // Next-state: request capture, per-stage shift, result commit and handshake
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    word_d  = word_q;
    amt_d   = amt_q;
    rev_d   = rev_q;
    cop_d   = cop_q;
    o_d     = o_q;
    co_d    = co_q;
    z_d     = z_q;

    // Shift amounts beyond W saturate at W.
    seff  = (s > SWP'(W)) ? SWP'(W) : s;
    idx_r = SW'(seff - SWP'(1));
    idx_l = SW'(SWP'(W) - seff);
    i_rev = bit_rev(i);

    sh_amt     = SWP'(1) << stg_q;
    stage_word = amt_q[stg_q] ? (word_q >> sh_amt) : word_q;
    res        = rev_q ? bit_rev(stage_word[W-1:0]) : stage_word[W-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          stg_d   = '0;
          amt_d   = seff;
          rev_d   = 1'b0;
          cop_d   = 1'b0;
          case (f)
            3'b000: begin
              word_d = {{W{1'b0}}, i};
              cop_d  = (seff != '0) ? i[idx_r] : 1'b0;
            end
            3'b001, 3'b011: begin
              word_d = {{W{1'b0}}, i_rev};
              rev_d  = 1'b1;
              cop_d  = (seff != '0) ? i[idx_l] : 1'b0;
            end
            3'b010: begin
              word_d = {{W{i[W-1]}}, i};
              cop_d  = (seff != '0) ? i[idx_r] : 1'b0;
            end
            3'b100: word_d = {i, i};
            3'b101: begin
              word_d = {i_rev, i_rev};
              rev_d  = 1'b1;
            end
            3'b110: word_d = {h, i};
            default: begin
              word_d = {{W{1'b0}}, i};
              amt_d  = '0;
            end
          endcase
        end
      end
      SHIFT: begin
        word_d = stage_word;
        if (stg_q == CW'(SW)) begin
          state_d = DONE;
          o_d     = res;
          co_d    = cop_q;
          z_d     = (res == '0);
        end else begin
          stg_d = stg_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stg_q   <= '0;
      word_q  <= '0;
      amt_q   <= '0;
      rev_q   <= 1'b0;
      cop_q   <= 1'b0;
      o_q     <= '0;
      co_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      word_q  <= word_d;
      amt_q   <= amt_d;
      rev_q   <= rev_d;
      cop_q   <= cop_d;
      o_q     <= o_d;
      co_q    <= co_d;
      z_q     <= z_d;
    end
  end

endmodule
